// File: rtl/wrr_arbiter_if.sv
// Request/grant and weight-configuration bundle for the weighted round-robin arbiter.
// master = requester/config side, slave = arbiter side.
interface wrr_arbiter_if #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned IDX_W    = 2
);
  logic [NREQ-1:0]     req;
  logic                beat;
  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_idx;
  logic [WEIGHT_W-1:0] cfg_weight;
  logic [NREQ-1:0]     gnt;
  logic                gnt_valid;
  logic [IDX_W-1:0]    gnt_id;
  logic [WEIGHT_W-1:0] credit;

  modport master (
    output req, beat, cfg_we, cfg_idx, cfg_weight,
    input  gnt, gnt_valid, gnt_id, credit
  );

  modport slave (
    input  req, beat, cfg_we, cfg_idx, cfg_weight,
    output gnt, gnt_valid, gnt_id, credit
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each grantee keeps the grant for up to weight[i]
// accepted beats, then rotation moves on with no idle bubble between grantees.
module wrr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  wrr_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state, nxt_state;
  logic [WEIGHT_W-1:0] weight [NREQ];
  logic [WEIGHT_W-1:0] wt_eff [NREQ];
  logic [NREQ-1:0]     elig, cand, gnt_q, nxt_gnt;
  logic [IDX_W-1:0]    ptr, nxt_ptr, gnt_id_q, nxt_gnt_id, base, win;
  logic [WEIGHT_W-1:0] credit_q, nxt_credit;
  logic                valid_q, found, rel, last_beat;

  // A write landing this cycle is already visible to eligibility and credit loads.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      wt_eff[i] = weight[i];
      if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) wt_eff[i] = bus.cfg_weight;
      elig[i] = bus.req[i] && (wt_eff[i] != '0);
    end
  end

  assign last_beat = bus.beat && (credit_q == WEIGHT_W'(1));
  assign rel       = (state == GRANT) &&
                     (last_beat || !bus.req[gnt_id_q] || (wt_eff[gnt_id_q] == '0));
  assign base      = (state == GRANT) ? gnt_id_q : ptr;
  assign cand      = (state == GRANT) ? (elig & ~(NREQ'(1) << gnt_id_q)) : elig;

  // First candidate scanning base+1, base+2, ... modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = base;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!found && cand[IDX_W'((int'(base) + k) % int'(NREQ))]) begin
        found = 1'b1;
        win   = IDX_W'((int'(base) + k) % int'(NREQ));
      end
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_gnt    = gnt_q;
    nxt_gnt_id = gnt_id_q;
    nxt_credit = credit_q;
    nxt_ptr    = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          nxt_state  = GRANT;
          nxt_gnt    = NREQ'(1) << win;
          nxt_gnt_id = win;
          nxt_credit = wt_eff[win];
        end
      end
      GRANT: begin
        if (rel) begin
          nxt_ptr = gnt_id_q;
          if (found) begin
            nxt_gnt    = NREQ'(1) << win;
            nxt_gnt_id = win;
            nxt_credit = wt_eff[win];
          end else if (elig[gnt_id_q]) begin
            nxt_credit = wt_eff[gnt_id_q];
          end else begin
            nxt_state  = IDLE;
            nxt_gnt    = '0;
            nxt_credit = '0;
          end
        end else if (bus.beat && (credit_q != '0)) begin
          nxt_credit = credit_q - WEIGHT_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      gnt_id_q <= '0;
      credit_q <= '0;
      ptr      <= IDX_W'(NREQ - 1);
      for (int i = 0; i < int'(NREQ); i++) weight[i] <= WEIGHT_W'(1);
    end else begin
      state    <= nxt_state;
      gnt_q    <= nxt_gnt;
      valid_q  <= (nxt_state == GRANT);
      gnt_id_q <= nxt_gnt_id;
      credit_q <= nxt_credit;
      ptr      <= nxt_ptr;
      for (int i = 0; i < int'(NREQ); i++) weight[i] <= wt_eff[i];
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.credit    = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed and randomized checks of wrr_arbiter against a beat-counting reference
// model of the weighted round-robin rules.
module tb_wrr_arbiter;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned WEIGHT_W = 4;
  localparam int unsigned IDX_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  wrr_arbiter_if #(.NREQ(NREQ), .WEIGHT_W(WEIGHT_W), .IDX_W(IDX_W)) bus ();

  wrr_arbiter #(.NREQ(NREQ), .WEIGHT_W(WEIGHT_W), .IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: grant owner, beats consumed since the last load, rotation pointer.
  int m_wt[NREQ];
  bit m_busy;
  int m_id, m_ptr, m_load, m_used;

  function automatic int pick(int base, int excl, logic [NREQ-1:0] el);
    int j;
    for (int k = 1; k <= int'(NREQ); k++) begin
      j = (base + k) % int'(NREQ);
      if (el[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREQ); i++) m_wt[i] = 1;
    m_busy = 0; m_id = 0; m_ptr = int'(NREQ) - 1; m_load = 0; m_used = 0;
  endtask

  task automatic model_step();
    int weff[NREQ];
    logic [NREQ-1:0] el;
    int w;
    bit rel;
    for (int i = 0; i < int'(NREQ); i++) begin
      weff[i] = (bus.cfg_we && int'(bus.cfg_idx) == i) ? int'(bus.cfg_weight) : m_wt[i];
      el[i] = bus.req[i] && (weff[i] > 0);
    end
    if (!m_busy) begin
      w = pick(m_ptr, -1, el);
      if (w >= 0) begin m_busy = 1; m_id = w; m_load = weff[w]; m_used = 0; end
    end else begin
      rel = (bus.beat && (m_load - m_used) == 1) || !bus.req[m_id] || weff[m_id] == 0;
      if (rel) begin
        m_ptr = m_id;
        w = pick(m_id, m_id, el);
        if (w >= 0) begin m_id = w; m_load = weff[w]; m_used = 0; end
        else if (el[m_id]) begin m_load = weff[m_id]; m_used = 0; end
        else m_busy = 0;
      end else if (bus.beat) begin
        m_used++;
      end
    end
    for (int i = 0; i < int'(NREQ); i++) m_wt[i] = weff[i];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".gnt"},    32'(bus.gnt),       m_busy ? (32'd1 << m_id) : 32'd0);
    chk({tag, ".valid"},  32'(bus.gnt_valid), 32'(m_busy));
    chk({tag, ".gnt_id"}, 32'(bus.gnt_id),    32'(m_id));
    chk({tag, ".credit"}, 32'(bus.credit),    m_busy ? 32'(m_load - m_used) : 32'd0);
  endtask

  // One clock: model consumes the inputs, DUT samples them, outputs checked just after.
  task automatic cyc(input logic [NREQ-1:0] r, input logic b, input string tag);
    bus.req = r; bus.beat = b;
    model_step();
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    chk_model(tag);
  endtask

  task automatic cyc_cfg(input logic [NREQ-1:0] r, input logic b, input int idx, input int w,
                         input string tag);
    bus.cfg_we = 1'b1; bus.cfg_idx = IDX_W'(idx); bus.cfg_weight = WEIGHT_W'(w);
    cyc(r, b, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.req = '0; bus.beat = 1'b0; bus.cfg_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  int exp_id[8];
  int exp_cr[8];

  initial begin
    bus.req = '0; bus.beat = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_weight = '0;
    model_reset();
    do_reset();
    chk("rst.gnt", 32'(bus.gnt), 32'd0);
    chk("rst.valid", 32'(bus.gnt_valid), 32'd0);
    chk("rst.gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("rst.credit", 32'(bus.credit), 32'd0);

    // Single requester, weight 1: one-cycle latency, re-grant on every beat.
    cyc(4'b0001, 1'b0, "p0.first");
    chk("p0.first.gnt", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0001, 1'b1, "p0.beat");
      chk("p0.regrant.credit", 32'(bus.credit), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1 chk("async_rst.gnt", 32'(bus.gnt), 32'd0);
    chk("async_rst.valid", 32'(bus.gnt_valid), 32'd0);
    do_reset();

    // Equal weights: plain rotation with no idle cycles.
    exp_id = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 1'b1, "rot");
      chk("rot.id", 32'(bus.gnt_id), 32'(exp_id[i]));
      chk("rot.valid", 32'(bus.gnt_valid), 32'd1);
    end

    // Weights {3,1,2,1}.
    do_reset();
    cyc_cfg(4'b0000, 1'b0, 0, 3, "wcfg0");
    cyc_cfg(4'b0000, 1'b0, 2, 2, "wcfg2");
    exp_id = '{0, 0, 0, 1, 2, 2, 3, 0};
    exp_cr = '{3, 2, 1, 1, 2, 1, 1, 3};
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, 1'b1, "wrr");
      chk("wrr.id", 32'(bus.gnt_id), 32'(exp_id[i]));
      chk("wrr.credit", 32'(bus.credit), 32'(exp_cr[i]));
    end

    // Port 1 withdraws mid-grant with credit left.
    do_reset();
    cyc_cfg(4'b0000, 1'b0, 1, 4, "wd.cfg");
    cyc(4'b1010, 1'b0, "wd.grant");
    chk("wd.grant.credit", 32'(bus.credit), 32'd4);
    cyc(4'b1010, 1'b1, "wd.b1");
    cyc(4'b1010, 1'b1, "wd.b2");
    chk("wd.credit_left", 32'(bus.credit), 32'd2);
    cyc(4'b1000, 1'b0, "wd.drop");
    chk("wd.next.gnt", 32'(bus.gnt), 32'h8);

    // Weight of the grantee written to 0.
    do_reset();
    cyc(4'b0100, 1'b0, "w0.grant2");
    cyc_cfg(4'b0110, 1'b0, 2, 0, "w0.kill");
    chk("w0.kill.gnt", 32'(bus.gnt), 32'h2);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0110, 1'b1, "w0.hold");
      chk("w0.p1only.gnt", 32'(bus.gnt), 32'h2);
    end
    cyc_cfg(4'b0110, 1'b1, 2, 1, "w0.revive");
    chk("w0.revive.gnt", 32'(bus.gnt), 32'h4);

    // Lone requester with weight 2: back-to-back re-grants.
    do_reset();
    cyc_cfg(4'b0000, 1'b0, 3, 2, "lone.cfg");
    exp_cr = '{2, 1, 2, 1, 2, 1, 2, 1};
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1000, 1'b1, "lone");
      chk("lone.gnt", 32'(bus.gnt), 32'h8);
      chk("lone.credit", 32'(bus.credit), 32'(exp_cr[i]));
    end

    // Randomized traffic, beats and weight writes.
    do_reset();
    begin
      logic [NREQ-1:0] r;
      r = '0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0)
          cyc_cfg(r, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), "rnd.cfg");
        else
          cyc(r, 1'($urandom_range(0, 3) != 0), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Weighted round-robin arbiter that shares one beat-oriented resource (bus, memory port, shared datapath) among NREQ requesters. Each requester holds the grant for up to a programmable number of accepted beats (its weight), then rotates to the next requester. It replaces a fixed four-level round-robin arbiter where requesters need unequal bandwidth shares. Weights are written through a simple configuration port.

Parameters:
NREQ, 4, number of requesters (2..8)
WEIGHT_W, 4, width of each weight and of the beat credit counter
IDX_W, 2, width of requester index (clog2(NREQ))

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  request per requester; level, held until served
beat  input  1  resource accepted one beat from the current grantee this cycle
cfg_we  input  1  weight write strobe
cfg_idx  input  IDX_W  requester index for weight write
cfg_weight  input  WEIGHT_W  weight value; 0 = requester disabled
gnt  output  NREQ  one-hot grant, registered
gnt_valid  output  1  OR of gnt, registered
gnt_id  output  IDX_W  binary index of grantee; holds last value when idle
credit  output  WEIGHT_W  beats remaining in current grant

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: gnt=0, gnt_valid=0, gnt_id=0, credit=0, all weights=1, rotation pointer ptr=NREQ-1 (port 0 has first priority), FSM=IDLE.
- Eligible mask: elig[i] = req[i] & (weight[i]!=0).
- FSM states: IDLE and GRANT.
- IDLE: if any elig, the grant is registered next edge. Latency is one cycle from req to gnt. Pick the first eligible index scanning ptr+1, ptr+2, ... modulo NREQ. Load credit=weight[winner], go to GRANT. Otherwise stay IDLE with gnt=0.
- GRANT, beat=1: credit decrements by 1.
- Release conditions, evaluated each GRANT cycle:
  - (a) beat=1 and credit==1 (weight exhausted);
  - (b) req[gnt_id]==0 (requester withdrew), with or without a beat;
  - (c) weight[gnt_id] written to 0 this cycle.
- On release: ptr<=gnt_id. Arbitration runs in the same cycle over current elig with the current grantee excluded, scanning from gnt_id+1.
  - If another requester is eligible: gnt switches at the next edge with no idle bubble, and credit reloads.
  - Else, if the current grantee is still eligible (case a only): it is re-granted with credit reloaded.
  - Else: FSM goes to IDLE and gnt=0 next cycle.
- No release: gnt, gnt_id and ptr are held. Credit never underflows, and beat is ignored when gnt_valid=0.
- Weight writes take effect at the next credit load. The in-flight credit is unaffected, except for the weight-0 release in (c).
- Simultaneous cfg_we to the grantee and release: the new weight is used if the same requester is re-granted.
- Only one gnt bit is ever high, and gnt_id is consistent with gnt whenever gnt_valid=1.
- Asynchronous reset mid-grant drops gnt immediately and restores all reset values, weights included.
- All outputs are registers. There is no combinational path from req or beat to gnt.

Test Plan:
- Reset then req=4'b0001 with weights all 1: gnt=0001 one cycle after req. Each beat re-grants port 0 with credit=1. Assert rst_n low mid-grant: gnt=0 immediately.
- req=4'b1111, weights 1, beat every cycle: grants rotate 0,1,2,3,0 with one beat each and no idle cycles.
- Weights {3,1,2,1} (port0..3), req=1111, beat every cycle: grant sequence 0,0,0,1,2,2,3 repeating. Credit counts 3,2,1 on port 0.
- Port 1 granted with weight 4, req[1] drops after 2 beats: release with credit=2. The next eligible port is granted on the following edge, and ptr=1.
- Write weight[2]=0 while port 2 is granted and req=0110: port 2 releases and port 1 is granted next. Port 2 is never granted again until its weight is rewritten non-zero.
- Only req[3] high, weight 2, beats continuous: gnt stays 1000 and credit reloads to 2 after every second beat, with no idle cycle between grants.
